// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the SCPU hazard controller.
//   - NPC_* : next-PC op encodings, matching the SCPU ctrl_encode_def values.
//   - FWD_* : operand forwarding selects used by the EX and ID operand muxes.
//   - state_e : controller FSM states.
//   - reg_hit : "writer targets this source" test shared by the stall logic.
package pipe_hazard_ctrl_pkg;

   localparam int unsigned REG_W = 5;
   localparam int unsigned NPC_W = 3;

   localparam logic [NPC_W-1:0] NPC_PLUS4  = 3'b000;
   localparam logic [NPC_W-1:0] NPC_BRANCH = 3'b001;
   localparam logic [NPC_W-1:0] NPC_JUMP   = 3'b010;
   localparam logic [NPC_W-1:0] NPC_JALR   = 3'b100;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_MEM  = 2'b01;
   localparam logic [1:0] FWD_WB   = 2'b10;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_e;

   // A write to x0 never creates a dependence.
   function automatic logic reg_hit(input logic wr_en, input logic [REG_W-1:0] rd,
                                    input logic use_en, input logic [REG_W-1:0] rs);
      return wr_en && use_en && (rd != '0) && (rd == rs);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Forwarding select for one operand.
// Ports:
//   rs_i            source register of the consuming instruction
//   mem_rd_i        MEM-stage destination, with mem_reg_write_i / mem_mem_read_i
//   wb_rd_i         WB-stage destination, with wb_reg_write_i
//   sel_o           FWD_MEM if a non-load in MEM writes rs, else FWD_WB if WB writes rs,
//                   else FWD_NONE
module pipe_hazard_ctrl_fwd_sel
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] rs_i,
   input  logic [REG_W-1:0] mem_rd_i,
   input  logic             mem_reg_write_i,
   input  logic             mem_mem_read_i,
   input  logic [REG_W-1:0] wb_rd_i,
   input  logic             wb_reg_write_i,
   output logic [1:0]       sel_o
);

   always_comb begin
      sel_o = FWD_NONE;
      // A load in MEM has no data yet; the load-use stall covers that case.
      if (reg_hit(mem_reg_write_i && !mem_mem_read_i, mem_rd_i, 1'b1, rs_i)) begin
         sel_o = FWD_MEM;
      end else if (reg_hit(wb_reg_write_i, wb_rd_i, 1'b1, rs_i)) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage SCPU pipeline.
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   ID_* / EX_* / MEM_* / WB_*  per-stage register numbers and control bits
//   mem_req, mem_ready         data-port handshake from the MEM stage
//   pc_en, *_en                PC and pipeline-register load enables
//   if_id_flush, id_ex_flush   load a bubble on the next edge
//   fwd_a, fwd_b               EX ALU operand selects
//   fwd_id_a, fwd_id_b         ID branch/JALR compare operand selects
//   mem_err                    sticky data-access timeout flag
//   stall_cycles, flush_count  performance counters (wrap)
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned TO_W        = 5,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] ID_rs1,
   input  logic [REG_W-1:0] ID_rs2,
   input  logic             ID_use_rs1,
   input  logic             ID_use_rs2,
   input  logic [NPC_W-1:0] ID_NPCOp,
   input  logic [REG_W-1:0] EX_rd,
   input  logic             EX_RegWrite,
   input  logic             EX_MemRead,
   input  logic [REG_W-1:0] EX_rs1,
   input  logic [REG_W-1:0] EX_rs2,
   input  logic [REG_W-1:0] MEM_rd,
   input  logic             MEM_RegWrite,
   input  logic             MEM_MemRead,
   input  logic [REG_W-1:0] WB_rd,
   input  logic             WB_RegWrite,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [1:0]       fwd_id_a,
   output logic [1:0]       fwd_id_b,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   state_e           state_q, state_d;
   logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic             mem_err_q;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   logic miss, timeout_hit, freeze;
   logic load_use, id_cmp, stall, do_flush;
   logic [1:0] fwd_a_raw, fwd_b_raw, fwd_id_a_raw, fwd_id_b_raw;

   // ---------------- memory wait FSM ----------------
   assign miss        = mem_req && !mem_ready;
   assign timeout_hit = (state_q == MEM_WAIT) && (wait_cnt_q == TO_W'(MEM_TIMEOUT - 1));
   // Freeze starts in the first miss cycle, before the FSM has left RUN.
   assign freeze      = miss && !timeout_hit;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         RUN: begin
            wait_cnt_d = '0;
            if (miss) state_d = MEM_WAIT;
         end
         MEM_WAIT: begin
            if (mem_ready || timeout_hit) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else begin
               wait_cnt_d = wait_cnt_q + TO_W'(1);
            end
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   // ---------------- stall detection ----------------
   assign load_use = reg_hit(EX_MemRead, EX_rd, ID_use_rs1, ID_rs1) ||
                     reg_hit(EX_MemRead, EX_rd, ID_use_rs2, ID_rs2);

   // ID compares need final values: an ALU result still in EX, or a load in MEM.
   assign id_cmp = ((ID_NPCOp == NPC_BRANCH) || (ID_NPCOp == NPC_JALR)) &&
                   (reg_hit(EX_RegWrite, EX_rd, ID_use_rs1, ID_rs1) ||
                    reg_hit(EX_RegWrite, EX_rd, ID_use_rs2, ID_rs2) ||
                    reg_hit(MEM_MemRead, MEM_rd, ID_use_rs1, ID_rs1) ||
                    reg_hit(MEM_MemRead, MEM_rd, ID_use_rs2, ID_rs2));

   assign stall = load_use || id_cmp;

   // Priority: reset, freeze, stall, control-transfer flush.
   always_comb begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      do_flush    = 1'b0;
      if (reset && !freeze) begin
         pc_en     = 1'b1;
         if_id_en  = 1'b1;
         id_ex_en  = 1'b1;
         ex_mem_en = 1'b1;
         mem_wb_en = 1'b1;
         if (stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
         end else if (ID_NPCOp != NPC_PLUS4) begin
            if_id_flush = 1'b1;
            do_flush    = 1'b1;
         end
      end
   end

   // ---------------- forwarding ----------------
   pipe_hazard_ctrl_fwd_sel u_fwd_ex_a (
      .rs_i(EX_rs1), .mem_rd_i(MEM_rd), .mem_reg_write_i(MEM_RegWrite),
      .mem_mem_read_i(MEM_MemRead), .wb_rd_i(WB_rd), .wb_reg_write_i(WB_RegWrite),
      .sel_o(fwd_a_raw)
   );
   pipe_hazard_ctrl_fwd_sel u_fwd_ex_b (
      .rs_i(EX_rs2), .mem_rd_i(MEM_rd), .mem_reg_write_i(MEM_RegWrite),
      .mem_mem_read_i(MEM_MemRead), .wb_rd_i(WB_rd), .wb_reg_write_i(WB_RegWrite),
      .sel_o(fwd_b_raw)
   );
   pipe_hazard_ctrl_fwd_sel u_fwd_id_a (
      .rs_i(ID_rs1), .mem_rd_i(MEM_rd), .mem_reg_write_i(MEM_RegWrite),
      .mem_mem_read_i(MEM_MemRead), .wb_rd_i(WB_rd), .wb_reg_write_i(WB_RegWrite),
      .sel_o(fwd_id_a_raw)
   );
   pipe_hazard_ctrl_fwd_sel u_fwd_id_b (
      .rs_i(ID_rs2), .mem_rd_i(MEM_rd), .mem_reg_write_i(MEM_RegWrite),
      .mem_mem_read_i(MEM_MemRead), .wb_rd_i(WB_rd), .wb_reg_write_i(WB_RegWrite),
      .sel_o(fwd_id_b_raw)
   );

   assign fwd_a    = reset ? fwd_a_raw    : FWD_NONE;
   assign fwd_b    = reset ? fwd_b_raw    : FWD_NONE;
   assign fwd_id_a = reset ? fwd_id_a_raw : FWD_NONE;
   assign fwd_id_b = reset ? fwd_id_b_raw : FWD_NONE;

   // ---------------- state and counters ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (timeout_hit && !mem_ready) mem_err_q <= 1'b1;
         if (!pc_en) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (do_flush) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign mem_err      = mem_err_q;
   assign stall_cycles = stall_cnt_q;
   assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the stimulus process pushes hand-computed
// expectations for each cycle; a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

   localparam logic [2:0] N_PLUS4 = 3'b000;
   localparam logic [2:0] N_BR    = 3'b001;
   localparam logic [2:0] N_JUMP  = 3'b010;
   localparam logic [2:0] N_JALR  = 3'b100;

   localparam logic [4:0] EN_ALL = 5'b11111;
   localparam logic [4:0] EN_STL = 5'b00111;
   localparam logic [4:0] EN_FRZ = 5'b00000;
   localparam logic [1:0] FL_NO  = 2'b00;
   localparam logic [1:0] FL_IF  = 2'b10;
   localparam logic [1:0] FL_EX  = 2'b01;

   logic       clk, reset;
   logic [4:0] ID_rs1, ID_rs2, EX_rd, EX_rs1, EX_rs2, MEM_rd, WB_rd;
   logic       ID_use_rs1, ID_use_rs2, EX_RegWrite, EX_MemRead;
   logic       MEM_RegWrite, MEM_MemRead, WB_RegWrite, mem_req, mem_ready;
   logic [2:0] ID_NPCOp;
   logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic       if_id_flush, id_ex_flush, mem_err;
   logic [1:0] fwd_a, fwd_b, fwd_id_a, fwd_id_b;
   logic [31:0] stall_cycles, flush_count;

   pipe_hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
      .ID_NPCOp(ID_NPCOp),
      .EX_rd(EX_rd), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
      .EX_rs1(EX_rs1), .EX_rs2(EX_rs2),
      .MEM_rd(MEM_rd), .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead),
      .WB_rd(WB_rd), .WB_RegWrite(WB_RegWrite),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
      .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b),
      .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [4:0]  en;
      logic [1:0]  fl;
      logic [1:0]  fa, fb, ia, ib;
      logic        err;
      logic [31:0] sc, fc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                      input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s.%s actual=%0h expected=%0h (t=%0t)", nm, fld, act, want, $time);
      end
   endtask

   // Monitor: outputs are sampled mid-cycle, away from the rising edge.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         cmp(e.name, "en", {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, {27'd0, e.en});
         cmp(e.name, "flush", {30'd0, if_id_flush, id_ex_flush}, {30'd0, e.fl});
         cmp(e.name, "fwd_a", {30'd0, fwd_a}, {30'd0, e.fa});
         cmp(e.name, "fwd_b", {30'd0, fwd_b}, {30'd0, e.fb});
         cmp(e.name, "fwd_id_a", {30'd0, fwd_id_a}, {30'd0, e.ia});
         cmp(e.name, "fwd_id_b", {30'd0, fwd_id_b}, {30'd0, e.ib});
         cmp(e.name, "mem_err", {31'd0, mem_err}, {31'd0, e.err});
         cmp(e.name, "stall_cycles", stall_cycles, e.sc);
         cmp(e.name, "flush_count", flush_count, e.fc);
      end
   end

   task automatic clr();
      ID_rs1 = 0; ID_rs2 = 0; ID_use_rs1 = 0; ID_use_rs2 = 0; ID_NPCOp = N_PLUS4;
      EX_rd = 0; EX_RegWrite = 0; EX_MemRead = 0; EX_rs1 = 0; EX_rs2 = 0;
      MEM_rd = 0; MEM_RegWrite = 0; MEM_MemRead = 0; WB_rd = 0; WB_RegWrite = 0;
      mem_req = 0; mem_ready = 0;
   endtask

   // Push the expectation for the inputs currently applied, then advance one cycle.
   task automatic chk(input string nm, input logic [4:0] en, input logic [1:0] fl,
                      input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] ia,
                      input logic [1:0] ib, input logic err, input int unsigned sc,
                      input int unsigned fc);
      exp_t e;
      e.name = nm; e.en = en; e.fl = fl; e.fa = fa; e.fb = fb; e.ia = ia; e.ib = ib;
      e.err = err; e.sc = sc; e.fc = fc;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      reset = 1'b0;
      clr();
      @(posedge clk);
      #1;
      // Reset held 3 cycles; outputs stay zero even with hazards/branch on the inputs.
      chk("rst0", EN_FRZ, FL_NO, 0, 0, 0, 0, 0, 0, 0);
      chk("rst1", EN_FRZ, FL_NO, 0, 0, 0, 0, 0, 0, 0);
      ID_NPCOp = N_BR; WB_rd = 5; WB_RegWrite = 1; EX_rs1 = 5; ID_rs1 = 5;
      chk("rst2", EN_FRZ, FL_NO, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      clr();
      chk("idle", EN_ALL, FL_NO, 0, 0, 0, 0, 0, 0, 0);

      // lw x5 in EX, add x6,x5,x1 in ID
      EX_rd = 5; EX_MemRead = 1; EX_RegWrite = 1;
      ID_rs1 = 5; ID_rs2 = 1; ID_use_rs1 = 1; ID_use_rs2 = 1;
      chk("lu_stall", EN_STL, FL_EX, 0, 0, 0, 0, 0, 0, 0);
      clr();
      MEM_rd = 5; MEM_MemRead = 1; MEM_RegWrite = 1;
      ID_rs1 = 5; ID_rs2 = 1; ID_use_rs1 = 1; ID_use_rs2 = 1;
      chk("lu_go", EN_ALL, FL_NO, 0, 0, 0, 0, 0, 1, 0);
      clr();
      EX_rs1 = 5; EX_rs2 = 1; EX_rd = 6; EX_RegWrite = 1; WB_rd = 5; WB_RegWrite = 1;
      chk("lu_fwd", EN_ALL, FL_NO, 2'b10, 0, 0, 0, 0, 1, 0);

      // ALU chain
      clr();
      MEM_rd = 5; MEM_RegWrite = 1; EX_rs1 = 5; EX_rs2 = 5; EX_rd = 7; EX_RegWrite = 1;
      chk("alu_mem", EN_ALL, FL_NO, 2'b01, 2'b01, 0, 0, 0, 1, 0);
      WB_rd = 5; WB_RegWrite = 1; ID_rs1 = 5; ID_rs2 = 9;
      chk("alu_mem_wb", EN_ALL, FL_NO, 2'b01, 2'b01, 2'b01, 0, 0, 1, 0);
      MEM_rd = 0; WB_rd = 0; EX_rs1 = 0; ID_rs1 = 0;
      chk("alu_x0", EN_ALL, FL_NO, 0, 0, 0, 0, 0, 1, 0);
      WB_rd = 5; EX_rs1 = 5; ID_rs1 = 5;
      chk("alu_wb", EN_ALL, FL_NO, 2'b10, 2'b10, 2'b10, 0, 0, 1, 0);

      // Taken branch, no hazard
      clr();
      ID_NPCOp = N_BR; ID_rs1 = 1; ID_rs2 = 2; ID_use_rs1 = 1; ID_use_rs2 = 1;
      chk("br_flush", EN_ALL, FL_IF, 0, 0, 0, 0, 0, 1, 0);
      clr();
      chk("br_after", EN_ALL, FL_NO, 0, 0, 0, 0, 0, 1, 1);

      // Branch on a register written by EX: stall, then flush with MEM forwarding
      EX_rd = 3; EX_RegWrite = 1; ID_NPCOp = N_BR; ID_rs1 = 3; ID_use_rs1 = 1;
      chk("br_ex_stall", EN_STL, FL_EX, 0, 0, 0, 0, 0, 1, 1);
      clr();
      MEM_rd = 3; MEM_RegWrite = 1; ID_NPCOp = N_BR; ID_rs1 = 3; ID_use_rs1 = 1;
      chk("br_ex_flush", EN_ALL, FL_IF, 0, 0, 2'b01, 0, 0, 2, 1);

      // JALR on a load result still in MEM
      clr();
      ID_NPCOp = N_JALR; ID_rs1 = 8; ID_use_rs1 = 1; MEM_rd = 8; MEM_MemRead = 1;
      MEM_RegWrite = 1;
      chk("jalr_stall", EN_STL, FL_EX, 0, 0, 0, 0, 0, 2, 2);
      // JUMP does not compare registers, so an EX writer causes no stall
      clr();
      ID_NPCOp = N_JUMP; EX_rd = 4; EX_RegWrite = 1; ID_rs1 = 4; ID_use_rs1 = 1;
      chk("jump_flush", EN_ALL, FL_IF, 0, 0, 0, 0, 0, 3, 2);
      clr();
      chk("idle2", EN_ALL, FL_NO, 0, 0, 0, 0, 0, 3, 3);

      // Memory wait of 3 cycles; a pending branch flush is held off by the freeze
      mem_req = 1; ID_NPCOp = N_BR;
      chk("mw_frz0", EN_FRZ, FL_NO, 0, 0, 0, 0, 0, 3, 3);
      chk("mw_frz1", EN_FRZ, FL_NO, 0, 0, 0, 0, 0, 4, 3);
      chk("mw_frz2", EN_FRZ, FL_NO, 0, 0, 0, 0, 0, 5, 3);
      mem_ready = 1;
      chk("mw_done", EN_ALL, FL_IF, 0, 0, 0, 0, 0, 6, 3);
      clr();
      chk("mw_idle", EN_ALL, FL_NO, 0, 0, 0, 0, 0, 6, 4);

      // Timeout: 16 frozen cycles, then a forced release
      mem_req = 1;
      for (int i = 0; i < 16; i++) begin
         chk("to_frz", EN_FRZ, FL_NO, 0, 0, 0, 0, 0, 6 + i, 4);
      end
      chk("to_release", EN_ALL, FL_NO, 0, 0, 0, 0, 0, 22, 4);
      chk("to_refrz", EN_FRZ, FL_NO, 0, 0, 0, 0, 1, 22, 4);
      mem_ready = 1;
      chk("to_sticky", EN_ALL, FL_NO, 0, 0, 0, 0, 1, 23, 4);
      mem_ready = 0;
      chk("to_frz2", EN_FRZ, FL_NO, 0, 0, 0, 0, 1, 23, 4);
      // Reset mid-wait clears everything immediately
      reset = 1'b0;
      chk("to_rst", EN_FRZ, FL_NO, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      clr();
      chk("post_rst", EN_ALL, FL_NO, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipelined SCPU (IF/ID/EX/MEM/WB).
- Generates the per-stage enables and flushes, plus forwarding selects for the EX ALU operands and the ID-stage branch/JALR compare.
- Freezes the pipeline while the data memory port is not ready, with a bounded timeout.
- Keeps performance counters for stalls and flushes.
- Sits beside the pipeline registers in SCPU; its outputs drive the PC and pipeline-register enable/flush inputs and the operand muxes.

Parameters:
MEM_TIMEOUT, 16, maximum consecutive wait cycles on the data port before forced release.
TO_W, 5, width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  pipeline clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
ID_rs1, ID_rs2  in  5 each  source registers of the instruction in ID.
ID_use_rs1, ID_use_rs2  in  1 each  ID instruction actually reads rs1/rs2.
ID_NPCOp  in  3  next-PC op resolved in ID (NPC_PLUS4/BRANCH/JUMP/JALR encodings).
EX_rd  in  5  destination register of the EX instruction.
EX_RegWrite, EX_MemRead  in  1 each  EX instruction control bits.
EX_rs1, EX_rs2  in  5 each  source registers of the EX instruction.
MEM_rd  in  5  destination register of the MEM instruction.
MEM_RegWrite, MEM_MemRead  in  1 each  MEM instruction control bits.
WB_rd  in  5  destination register of the WB instruction.
WB_RegWrite  in  1  WB instruction control bit.
mem_req  in  1  MEM stage is performing a load or store.
mem_ready  in  1  data memory completes the access this cycle.
pc_en  out  1  PC register load enable.
if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register load enables.
if_id_flush, id_ex_flush  out  1 each  load a bubble (NOP / all control bits 0) on the next edge.
fwd_a, fwd_b  out  2 each  EX operand source: 00 pipe reg, 01 MEM_ALU_out, 10 WB_Write_Data.
fwd_id_a, fwd_id_b  out  2 each  ID compare operand source, same encoding as fwd_a/fwd_b.
mem_err  out  1  sticky: a data access timed out.
stall_cycles  out  CNT_W  count of cycles with pc_en = 0 outside reset.
flush_count  out  CNT_W  count of control-transfer flushes.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to RUN; wait counter, mem_err, stall_cycles and flush_count clear to 0.
  - While reset is held, all enables = 0, all flushes = 0, all fwd selects = 00.
- FSM states RUN and MEM_WAIT:
  - RUN -> MEM_WAIT when mem_req = 1 and mem_ready = 0.
  - MEM_WAIT -> RUN when mem_ready = 1 or the wait counter = MEM_TIMEOUT - 1.
    - On a timeout exit, set mem_err; it stays set until reset.
  - The wait counter increments each MEM_WAIT cycle and clears on entry to RUN.
- Freeze condition: (mem_req = 1 and mem_ready = 0) and no timeout release this cycle.
  - While frozen, all five enables = 0 and no flushes are asserted.
  - Freeze has the highest priority. It applies combinationally in the first miss cycle, so the request is held from its first cycle.
- Load-use stall: EX_MemRead = 1, EX_rd != 0, and EX_rd matches an ID source whose use flag is set.
- ID-compare stall: ID_NPCOp is BRANCH or JALR, and either of:
  - EX_RegWrite = 1, EX_rd != 0, EX_rd matches a used source;
  - MEM_MemRead = 1, MEM_rd != 0, MEM_rd matches a used source.
- Any stall (and no freeze): pc_en = 0, if_id_en = 0, id_ex_flush = 1; other enables = 1. Stall lasts exactly as long as the condition holds; a single load-use costs one cycle.
- Control-transfer flush: ID_NPCOp != PLUS4, with no stall and no freeze.
  - Set if_id_flush = 1 and increment flush_count.
  - The PC loads the target in the same cycle.
  - A flush request is suppressed during a stall or freeze and re-evaluated in the next cycle.
- EX forwarding, per operand (rs1 -> fwd_a, rs2 -> fwd_b), independent of stall state:
  - 01 if MEM_RegWrite = 1, MEM_rd != 0, MEM_rd = EX_rsX, MEM_MemRead = 0;
  - else 10 if WB_RegWrite = 1, WB_rd != 0, WB_rd = EX_rsX;
  - else 00.
  - The MEM match has priority over the WB match.
- ID forwarding: same priority rule applied to ID_rs1/ID_rs2 (MEM non-load -> 01, WB -> 10). A hit on x0 never forwards.
- stall_cycles increments in every non-reset cycle with pc_en = 0. Both counters wrap modulo 2^CNT_W.

Decomposition:
- Shared package/define header: NPC_* encodings (existing ctrl_encode_def), FWD_NONE/FWD_MEM/FWD_WB codes, and state encodings RUN/MEM_WAIT.
- One natural sub-module: fwd_sel. It is combinational and instantiated four times (EX a/b, ID a/b): inputs are the source register, MEM rd/RegWrite/MemRead and WB rd/RegWrite; output is the 2-bit select.
- FSM, stall logic and counters live in the top-level module.

Test Plan:
- Reset sequence: hold reset = 0 for 3 cycles, then release. Outputs during reset are all 0; counters are 0 at release; with no hazards, the first cycle after release has all enables = 1.
- Load-use: "lw x5,0(x0)" in EX with "add x6,x5,x1" in ID. Exactly one cycle of pc_en = 0 and id_ex_flush = 1. Next cycle fwd_a = 10. stall_cycles = 1.
- ALU chain: "add x5,..." in MEM and "sub x7,x5,x5" in EX gives fwd_a = fwd_b = 01. With x5 also in WB, the MEM match still wins (01). With rd = x0 in MEM, the select is 00.
- Taken branch: beq in ID with ID_NPCOp = BRANCH, no hazard. One cycle of if_id_flush = 1; flush_count goes 0 -> 1. Branch on a reg written by EX: one stall cycle, then flush.
- Memory wait: mem_req = 1 with mem_ready low for 3 cycles. Enables are 0 for 3 cycles, state returns to RUN on the 4th cycle, mem_err = 0, stall_cycles += 3.
- Timeout: mem_ready held 0 with MEM_TIMEOUT = 16. Forced release after the 16th wait cycle; mem_err = 1 and stays set. Asserting reset mid-wait returns state to RUN and clears mem_err immediately.
